alu_array_pipe: RTL and testbench
=================================

// Module: alu_array_pipe
// PURPOSE
//  Parametrised successor to the dual 8-bit ALU macro: NCH independent ALU lanes of WIDTH bits,
//  each with an 8-op opcode and a per-lane accumulator mode. A 2-stage pipeline uses a
//  valid/ready handshake. Sits behind the LA/IO test harness of the user project wrapper.
//  Outputs the cross-lane XOR word and its parity, plus a transaction counter.
// PARAMETERS
//  WIDTH  8   lane datapath width in bits; must be >= 2
//  NCH    2   number of lanes; must be >= 1
//  CNTW   16  width of the completed-transaction counter
// PORTS
//  wb_clk_i     in   1          clock; all logic on rising edge
//  wb_rst_ni    in   1          synchronous, active-low reset
//  in_valid_i   in   1          operand bundle valid
//  in_ready_o   out  1          block accepts the bundle this cycle
//  a_i          in   NCH*WIDTH  operand A; lane k = a_i[k*WIDTH +: WIDTH]
//  b_i          in   NCH*WIDTH  operand B, same packing
//  op_i         in   NCH*3      per-lane opcode
//  acc_mode_i   in   NCH        1 = lane uses its accumulator as A and writes the result back
//  clr_acc_i    in   1          clear all accumulators (synchronous, single cycle)
//  out_valid_o  out  1          result bundle valid
//  out_ready_i  in   1          consumer accepts the result
//  res_o        out  NCH*WIDTH  lane results
//  carry_o      out  NCH        per-lane carry/borrow/shift-out
//  zero_o       out  NCH        per-lane result == 0
//  ovf_o        out  NCH        per-lane signed overflow
//  xor_o        out  WIDTH      XOR of all lane results
//  par_o        out  1          ^xor_o
//  op_cnt_o     out  CNTW       count of output handshakes
// BEHAVIOUR
//  Reset (wb_rst_ni=0 at edge): all outputs, s1/s2 valid bits, accumulators, and op_cnt_o are 0.
//    Reset mid-operation drops in-flight data.
//  Handshake: in_ready_o = !s1_v | adv1 (combinational).
//    adv2 = !s2_v | out_ready_i; adv1 = adv2.
//    Accept when in_valid_i & in_ready_o. out_valid_o = s2_v.
//    res/flags hold stable while out_valid_o & !out_ready_i.
//  Stage1 registers a_i, b_i, op_i, and acc_mode_i on accept.
//  The lane compute is combinational on s1 regs and is captured into s2 when adv2 & s1_v.
//  Latency is 2 cycles from accept to out_valid_o; throughput is 1 bundle/cycle with no stall.
//  Opcodes (carry / ovf):
//    000 ADD  a+b     carry = bit WIDTH out; ovf = signed overflow
//    001 SUB  a-b     carry = borrow (a<b unsigned); ovf = signed overflow
//    010 AND; 011 OR; 100 XOR; 101 XNOR   carry = 0; ovf = 0
//    110 SHL  a<<s    s = b[$clog2(WIDTH)-1:0]; carry = last bit shifted out (0 if s=0); ovf = 0
//    111 SHR  a>>s    logical; carry as for SHL
//  Accumulator mode: A = acc[k], sampled when the op moves s1->s2.
//    On the same edge acc[k] <= result, so back-to-back accumulate ops chain with no bubble.
//  clr_acc_i: all acc <= 0 on that edge. It wins over a simultaneous write-back.
//    The in-flight result is still output unchanged.
//    A bundle entering s2 in the clear cycle already sampled the old acc.
//  zero_o is computed on the WIDTH-bit result only (carry excluded).
//  xor_o and par_o are registered with s2.
//  op_cnt_o increments on out_valid_o & out_ready_i and wraps from all-ones to 0.
//  Stalled s1 with in_valid_i high: in_ready_o = 0; the upstream bundle holds and is not lost.
// STRUCTURE
//  alu_array_pkg: opcode localparams OP_ADD..OP_SHR and OPW = 3.
//  Sub-module alu_lane (combinational): a, b, op -> res, carry, zero, ovf.
//    alu_array_pipe generates NCH instances; the pipeline regs, accumulators, and counter live in the top.
// TESTING
//  1 Defaults, lane0 ADD 0xF0+0x20, lane1 SUB 0x10-0x20
//      -> after 2 cycles res = {0xF0, 0x10}; carry = {1, 1}; ovf = 0; xor_o = 0xE0; par_o = 1
//  2 ADD 0x7F+0x01 -> res 0x80, ovf = 1, carry = 0
//    SHL 0x81 by 1 -> res 0x02, carry = 1
//    XNOR 0xFF,0x00 -> res 0x00, zero = 1
//  3 acc_mode on lane0: ADD b = 5 on 4 consecutive cycles
//      -> results 5, 10, 15, 20 on consecutive cycles
//    assert clr_acc_i, then ADD b = 3 -> result 3
//  4 out_ready_i low for 5 cycles while 3 bundles are offered
//      -> exactly 2 are held (in_ready_o drops); outputs stable
//    on release the bundles drain in order with none lost or duplicated
//  5 Reset asserted with both stages full and acc = 0x33
//      -> next cycle out_valid_o = 0, acc = 0, op_cnt_o = 0
//  6 CNTW = 4: 17 handshakes -> op_cnt_o reads 1 (wrap)
//    NCH = 4, WIDTH = 16 random ops checked against a reference model

Source files
------------

// File: rtl/alu_array_pkg.sv
// Shared opcode encoding for the ALU lane array.
package alu_array_pkg;

    localparam int OPW = 3;

    localparam logic [OPW-1:0] OP_ADD  = 3'd0;
    localparam logic [OPW-1:0] OP_SUB  = 3'd1;
    localparam logic [OPW-1:0] OP_AND  = 3'd2;
    localparam logic [OPW-1:0] OP_OR   = 3'd3;
    localparam logic [OPW-1:0] OP_XOR  = 3'd4;
    localparam logic [OPW-1:0] OP_XNOR = 3'd5;
    localparam logic [OPW-1:0] OP_SHL  = 3'd6;
    localparam logic [OPW-1:0] OP_SHR  = 3'd7;

endpackage

// File: rtl/alu_lane.sv
// One combinational ALU lane: eight ops with carry, zero and signed-overflow flags.
module alu_lane
    import alu_array_pkg::*;
#(
    parameter int WIDTH = 8
)
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   op,
    output logic [WIDTH-1:0] res,
    output logic             carry,
    output logic             zero,
    output logic             ovf
);

    localparam int SW = $clog2(WIDTH);

    logic [SW-1:0]  sh;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic [WIDTH:0] shl_ext;
    logic [WIDTH:0] shr_ext;

    assign sh   = b[SW-1:0];
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    // One guard bit on the far side of each shift catches the last bit shifted out.
    assign shl_ext = {1'b0, a} << sh;
    assign shr_ext = {a, 1'b0} >> sh;

    always_comb begin
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (op)
            OP_ADD: begin
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res   = diff[WIDTH-1:0];
                carry = diff[WIDTH];
                ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_XNOR: res = ~(a ^ b);
            OP_SHL: begin
                res   = shl_ext[WIDTH-1:0];
                carry = shl_ext[WIDTH];
            end
            OP_SHR: begin
                res   = shr_ext[WIDTH:1];
                carry = shr_ext[0];
            end
            default: ;
        endcase
    end

    assign zero = (res == '0);

endmodule

// File: rtl/alu_array_pipe.sv
// NCH-lane ALU array behind a 2-stage valid/ready pipeline with per-lane accumulators,
// cross-lane XOR/parity and a completed-transaction counter.
module alu_array_pipe
    import alu_array_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 2,
    parameter int CNTW  = 16
)
(
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [NCH*WIDTH-1:0]  a_i,
    input  logic [NCH*WIDTH-1:0]  b_i,
    input  logic [NCH*OPW-1:0]    op_i,
    input  logic [NCH-1:0]        acc_mode_i,
    input  logic                  clr_acc_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [NCH*WIDTH-1:0]  res_o,
    output logic [NCH-1:0]        carry_o,
    output logic [NCH-1:0]        zero_o,
    output logic [NCH-1:0]        ovf_o,
    output logic [WIDTH-1:0]      xor_o,
    output logic                  par_o,
    output logic [CNTW-1:0]       op_cnt_o
);

    logic                 s1_v_reg;
    logic [NCH*WIDTH-1:0] s1_a_reg;
    logic [NCH*WIDTH-1:0] s1_b_reg;
    logic [NCH*OPW-1:0]   s1_op_reg;
    logic [NCH-1:0]       s1_acc_mode_reg;

    logic                 s2_v_reg;
    logic [NCH*WIDTH-1:0] res_reg;
    logic [NCH-1:0]       carry_reg;
    logic [NCH-1:0]       zero_reg;
    logic [NCH-1:0]       ovf_reg;
    logic [WIDTH-1:0]     xor_reg;
    logic                 par_reg;
    logic [CNTW-1:0]      op_cnt_reg;

    logic [WIDTH-1:0]     acc_reg [NCH];

    logic [NCH*WIDTH-1:0] lane_a;
    logic [NCH*WIDTH-1:0] lane_res;
    logic [NCH-1:0]       lane_carry;
    logic [NCH-1:0]       lane_zero;
    logic [NCH-1:0]       lane_ovf;
    logic [WIDTH-1:0]     lane_xor;

    logic adv1;
    logic adv2;
    logic accept;
    logic s2_load;

    assign adv2       = !s2_v_reg || out_ready_i;
    assign adv1       = adv2;
    assign in_ready_o = !s1_v_reg || adv1;
    assign accept     = in_valid_i && in_ready_o;
    assign s2_load    = adv2 && s1_v_reg;

    // Accumulator lanes read acc here; the write-back below lands on the same edge,
    // so the next bundle in s1 already sees the updated value.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_lane
            assign lane_a[gi*WIDTH +: WIDTH] = s1_acc_mode_reg[gi] ? acc_reg[gi]
                                                                   : s1_a_reg[gi*WIDTH +: WIDTH];
            alu_lane #(
                .WIDTH (WIDTH)
            ) u_lane (
                .a     (lane_a[gi*WIDTH +: WIDTH]),
                .b     (s1_b_reg[gi*WIDTH +: WIDTH]),
                .op    (s1_op_reg[gi*OPW +: OPW]),
                .res   (lane_res[gi*WIDTH +: WIDTH]),
                .carry (lane_carry[gi]),
                .zero  (lane_zero[gi]),
                .ovf   (lane_ovf[gi])
            );
        end
    endgenerate

    always_comb begin
        lane_xor = '0;
        for (int k = 0; k < NCH; k++) begin
            lane_xor = lane_xor ^ lane_res[k*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            s1_v_reg        <= 1'b0;
            s1_a_reg        <= '0;
            s1_b_reg        <= '0;
            s1_op_reg       <= '0;
            s1_acc_mode_reg <= '0;
        end else if (in_ready_o) begin
            s1_v_reg <= in_valid_i;
            if (accept) begin
                s1_a_reg        <= a_i;
                s1_b_reg        <= b_i;
                s1_op_reg       <= op_i;
                s1_acc_mode_reg <= acc_mode_i;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            s2_v_reg  <= 1'b0;
            res_reg   <= '0;
            carry_reg <= '0;
            zero_reg  <= '0;
            ovf_reg   <= '0;
            xor_reg   <= '0;
            par_reg   <= 1'b0;
        end else if (adv2) begin
            s2_v_reg <= s1_v_reg;
            if (s1_v_reg) begin
                res_reg   <= lane_res;
                carry_reg <= lane_carry;
                zero_reg  <= lane_zero;
                ovf_reg   <= lane_ovf;
                xor_reg   <= lane_xor;
                par_reg   <= ^lane_xor;
            end
        end
    end

    // A clear on the same edge as a write-back wins.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni || clr_acc_i) begin
            for (int k = 0; k < NCH; k++) begin
                acc_reg[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (s2_load && s1_acc_mode_reg[k]) begin
                    acc_reg[k] <= lane_res[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            op_cnt_reg <= '0;
        end else if (s2_v_reg && out_ready_i) begin
            op_cnt_reg <= op_cnt_reg + CNTW'(1);
        end
    end

    assign out_valid_o = s2_v_reg;
    assign res_o       = res_reg;
    assign carry_o     = carry_reg;
    assign zero_o      = zero_reg;
    assign ovf_o       = ovf_reg;
    assign xor_o       = xor_reg;
    assign par_o       = par_reg;
    assign op_cnt_o    = op_cnt_reg;

endmodule

// File: tb/tb_alu_array_pipe.sv
// Bench for alu_array_pipe: directed 2x8-bit instance with a queue model, plus a
// randomised 4x16-bit instance checked against a streaming reference.
module tb_alu_array_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference lane: results from plain arithmetic on w-bit values held in 16 bits.
    function automatic void alu_ref(input int w, input logic [15:0] a, input logic [15:0] b,
                                    input logic [2:0] op, output logic [15:0] r,
                                    output logic c, output logic v);
        logic [16:0] full;
        logic [15:0] mask;
        int s;
        mask = 16'((32'd1 << w) - 1);
        s = int'(b) % w;
        c = 1'b0;
        v = 1'b0;
        r = '0;
        case (op)
            3'd0: begin
                full = {1'b0, a} + {1'b0, b};
                r = full[15:0] & mask;
                c = full[w];
                v = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
            end
            3'd1: begin
                r = (a - b) & mask;
                c = (a < b);
                v = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~(a ^ b) & mask;
            3'd6: begin
                r = (a << s) & mask;
                c = (s == 0) ? 1'b0 : a[w-s];
            end
            default: begin
                r = a >> s;
                c = (s == 0) ? 1'b0 : a[s-1];
            end
        endcase
    endfunction

    // ---------------- instance 1: NCH=2, WIDTH=8, CNTW=4 ----------------
    logic        rst_n, in_valid, clr, out_ready;
    logic [15:0] a, b;
    logic [5:0]  op;
    logic [1:0]  am;
    logic        in_ready, out_valid, par;
    logic [15:0] res;
    logic [1:0]  carry, zero, ovf;
    logic [7:0]  xo;
    logic [3:0]  cnt;

    alu_array_pipe #(.WIDTH(8), .NCH(2), .CNTW(4)) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .op_i        (op),
        .acc_mode_i  (am),
        .clr_acc_i   (clr),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .res_o       (res),
        .carry_o     (carry),
        .zero_o      (zero),
        .ovf_o       (ovf),
        .xor_o       (xo),
        .par_o       (par),
        .op_cnt_o    (cnt)
    );

    typedef struct { logic [15:0] a; logic [15:0] b; logic [5:0] op; logic [1:0] am; } bun_t;
    typedef struct { logic [15:0] res; logic [1:0] c; logic [1:0] z; logic [1:0] v;
                     logic [7:0] x; logic p; } rslt_t;

    bun_t       pend_q[$];
    rslt_t      outq[$];
    logic [7:0] m_acc [2];
    logic [3:0] m_cnt;
    int         n_acc = 0;
    logic [7:0] dut_log[$];
    bit         chk_en = 0;

    bun_t        m_bb;
    rslt_t       m_rr;
    logic [15:0] m_r16, m_opa;
    logic        m_c, m_v, m_free, m_fire, m_rdy;

    // Model: a bundle waits until the output register is free, is computed on the edge it
    // enters it (reading acc then), and leaves on an output handshake.
    always @(posedge clk) begin
        if (!rst_n) begin
            pend_q.delete();
            outq.delete();
            m_acc[0] = '0;
            m_acc[1] = '0;
            m_cnt = '0;
        end else begin
            m_free = (outq.size() == 0) || out_ready;
            m_fire = (outq.size() != 0) && out_ready;
            m_rdy  = (pend_q.size() == 0) || m_free;
            if (m_fire) begin
                void'(outq.pop_front());
                m_cnt = m_cnt + 4'd1;
            end
            if (m_free && pend_q.size() != 0) begin
                m_bb = pend_q.pop_front();
                for (int k = 0; k < 2; k++) begin
                    m_opa = m_bb.am[k] ? {8'h00, m_acc[k]} : {8'h00, m_bb.a[k*8 +: 8]};
                    alu_ref(8, m_opa, {8'h00, m_bb.b[k*8 +: 8]}, m_bb.op[k*3 +: 3], m_r16, m_c, m_v);
                    m_rr.res[k*8 +: 8] = m_r16[7:0];
                    m_rr.c[k] = m_c;
                    m_rr.v[k] = m_v;
                    m_rr.z[k] = (m_r16[7:0] == 8'h00);
                    if (m_bb.am[k]) m_acc[k] = m_r16[7:0];
                end
                m_rr.x = m_rr.res[7:0] ^ m_rr.res[15:8];
                m_rr.p = ^m_rr.x;
                outq.push_back(m_rr);
            end
            if (clr) begin
                m_acc[0] = '0;
                m_acc[1] = '0;
            end
            if (in_valid && m_rdy) begin
                pend_q.push_back('{a: a, b: b, op: op, am: am});
                n_acc++;
            end
        end
    end

    always begin
        @(negedge clk);
        #2;
        if (chk_en) begin
            check("out_valid", out_valid, outq.size() != 0);
            check("in_ready", in_ready, (pend_q.size() == 0) || (outq.size() == 0) || out_ready);
            check("op_cnt", cnt, m_cnt);
            if (outq.size() != 0) begin
                check("res", res, outq[0].res);
                check("carry", carry, outq[0].c);
                check("zero", zero, outq[0].z);
                check("ovf", ovf, outq[0].v);
                check("xor", xo, outq[0].x);
                check("par", par, outq[0].p);
            end
            if (out_valid && out_ready) dut_log.push_back(res[7:0]);
        end
    end

    // ---------------- instance 2: NCH=4, WIDTH=16, random ----------------
    logic        rst2_n, in_valid2;
    logic        out_ready2 = 1'b1;
    logic        clr2 = 1'b0;
    logic [63:0] a2, b2;
    logic [11:0] op2;
    logic [3:0]  am2;
    logic        in_ready2, out_valid2, par2;
    logic [63:0] res2;
    logic [3:0]  carry2, zero2, ovf2;
    logic [15:0] xo2, cnt2;
    bit          done2 = 0;

    alu_array_pipe #(.WIDTH(16), .NCH(4), .CNTW(16)) dut2 (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst2_n),
        .in_valid_i  (in_valid2),
        .in_ready_o  (in_ready2),
        .a_i         (a2),
        .b_i         (b2),
        .op_i        (op2),
        .acc_mode_i  (am2),
        .clr_acc_i   (clr2),
        .out_valid_o (out_valid2),
        .out_ready_i (out_ready2),
        .res_o       (res2),
        .carry_o     (carry2),
        .zero_o      (zero2),
        .ovf_o       (ovf2),
        .xor_o       (xo2),
        .par_o       (par2),
        .op_cnt_o    (cnt2)
    );

    typedef struct { logic [63:0] res; logic [3:0] c; logic [3:0] z; logic [3:0] v;
                     logic [15:0] x; logic p; } rslt2_t;
    rslt2_t      exp2[$];
    rslt2_t      e2;
    logic [15:0] acc2 [4];
    logic [1:0]  vh2;
    logic [15:0] pops2;
    logic [15:0] r2;
    logic        c2, v2;

    // Never stalled and never cleared, so each bundle's acc read follows acceptance order.
    always @(posedge clk) begin
        if (!rst2_n) begin
            exp2.delete();
            for (int k = 0; k < 4; k++) acc2[k] = '0;
            vh2 = '0;
        end else begin
            vh2 = {vh2[0], in_valid2};
            if (in_valid2) begin
                e2.x = '0;
                for (int k = 0; k < 4; k++) begin
                    alu_ref(16, am2[k] ? acc2[k] : a2[k*16 +: 16], b2[k*16 +: 16],
                            op2[k*3 +: 3], r2, c2, v2);
                    e2.res[k*16 +: 16] = r2;
                    e2.c[k] = c2;
                    e2.v[k] = v2;
                    e2.z[k] = (r2 == 16'h0);
                    e2.x = e2.x ^ r2;
                    if (am2[k]) acc2[k] = r2;
                end
                e2.p = ^e2.x;
                exp2.push_back(e2);
            end
        end
    end

    always begin
        @(negedge clk);
        #2;
        if (rst2_n) begin
            check("w16_out_valid", out_valid2, vh2[1]);
            if (out_valid2) begin
                if (exp2.size() == 0) begin
                    check("w16_unexpected_output", 1, 0);
                end else begin
                    e2 = exp2.pop_front();
                    check("w16_res", res2, e2.res);
                    check("w16_carry", carry2, e2.c);
                    check("w16_zero", zero2, e2.z);
                    check("w16_ovf", ovf2, e2.v);
                    check("w16_xor", xo2, e2.x);
                    check("w16_par", par2, e2.p);
                    check("w16_cnt", cnt2, pops2);
                    pops2 = pops2 + 16'd1;
                end
            end
        end
    end

    initial begin
        rst2_n = 1'b0;
        in_valid2 = 1'b0;
        a2 = '0; b2 = '0; op2 = '0; am2 = '0;
        pops2 = '0;
        repeat (3) @(negedge clk);
        rst2_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            in_valid2 = ($urandom_range(0, 3) != 0);
            a2  = {$urandom, $urandom};
            b2  = {$urandom, $urandom};
            op2 = 12'($urandom);
            am2 = (i < 100) ? 4'h0 : 4'($urandom);
            @(negedge clk);
        end
        in_valid2 = 1'b0;
        repeat (4) @(negedge clk);
        done2 = 1;
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic [15:0] av, input logic [15:0] bv,
                         input logic [5:0] opv, input logic [1:0] amv);
        a = av; b = bv; op = opv; am = amv; in_valid = 1'b1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    logic [7:0] t4_vals [3];
    int base, idx;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        t4_vals = '{8'h11, 8'h22, 8'h33};
        rst_n = 1'b0; in_valid = 1'b0; clr = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; op = '0; am = '0;
        tick();
        chk_en = 1;
        check("rst_out_valid", out_valid, 0);
        check("rst_res", res, 0);
        check("rst_flags", {carry, zero, ovf}, 0);
        check("rst_xor_par", {xo, par}, 0);
        check("rst_cnt", cnt, 0);
        tick();
        rst_n = 1'b1;

        // 1: lane0 ADD F0+20, lane1 SUB 10-20, two-cycle latency
        drive(16'h10F0, 16'h2020, 6'b001_000, 2'b00);
        tick();
        idle();
        tick();
        check("t1_valid", out_valid, 1);
        check("t1_res", res, 16'hF010);
        check("t1_carry", carry, 2'b11);
        check("t1_ovf", ovf, 2'b00);
        check("t1_xor", xo, 8'hE0);
        check("t1_par", par, 1);
        repeat (2) tick();

        // 2: ADD overflow + SHL carry, then XNOR giving zero
        drive(16'h817F, 16'h0101, 6'b110_000, 2'b00);
        tick();
        drive(16'h00FF, 16'h0000, 6'b010_101, 2'b00);
        tick();
        idle();
        check("t2a_res", res, 16'h0280);
        check("t2a_ovf", ovf, 2'b01);
        check("t2a_carry", carry, 2'b10);
        tick();
        check("t2b_res", res, 16'h0000);
        check("t2b_zero", zero, 2'b11);
        repeat (2) tick();

        // 3: lane0 accumulates +5 four times, clear, then +3
        for (int i = 0; i < 4; i++) begin
            drive(16'h00AA, 16'h0005, 6'b000_000, 2'b01);
            tick();
            if (i >= 1) check("t3_acc", res[7:0], 8'(5 * i));
        end
        idle();
        clr = 1'b1;
        tick();
        check("t3_acc_last", res[7:0], 8'd20);
        clr = 1'b0;
        drive(16'h00AA, 16'h0003, 6'b000_000, 2'b01);
        tick();
        idle();
        tick();
        check("t3_after_clr", res[7:0], 8'd3);
        repeat (3) tick();

        // 4: consumer stalled 5 cycles while 3 bundles are offered
        dut_log.delete();
        out_ready = 1'b0;
        base = n_acc;
        for (int cyc = 0; cyc < 5; cyc++) begin
            idx = n_acc - base;
            if (idx < 3) drive({8'h00, t4_vals[idx]}, 16'h0000, 6'b011_011, 2'b00);
            else idle();
            tick();
        end
        idx = n_acc - base;
        check("t4_held", idx, 2);
        if (idx < 3) drive({8'h00, t4_vals[idx]}, 16'h0000, 6'b011_011, 2'b00);
        #1;
        check("t4_in_ready_low", in_ready, 0);
        check("t4_out_held", {out_valid, res[7:0]}, {1'b1, 8'h11});
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 10 && (n_acc - base) < 3; cyc++) begin
            idx = n_acc - base;
            if (idx < 3) drive({8'h00, t4_vals[idx]}, 16'h0000, 6'b011_011, 2'b00);
            tick();
        end
        idle();
        repeat (4) tick();
        check("t4_drain_count", dut_log.size(), 3);
        for (int i = 0; i < 3 && i < dut_log.size(); i++) check("t4_drain_order", dut_log[i], t4_vals[i]);

        // 5: reset with both stages full and acc0 = 0x33
        drive(16'h0000, 16'h0033, 6'b000_000, 2'b01);
        tick();
        idle();
        repeat (3) tick();
        out_ready = 1'b0;
        drive(16'h0001, 16'h0000, 6'b011_011, 2'b00);
        tick();
        drive(16'h0002, 16'h0000, 6'b011_011, 2'b00);
        tick();
        idle();
        check("t5_full", out_valid, 1);
        rst_n = 1'b0;
        tick();
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_cnt", cnt, 0);
        check("t5_rst_res", res, 0);
        #1;
        check("t5_rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(16'h0000, 16'h0000, 6'b000_000, 2'b01);
        tick();
        idle();
        tick();
        check("t5_acc_cleared", {out_valid, res[7:0]}, {1'b1, 8'h00});
        repeat (2) tick();

        // 6: 17 handshakes on a 4-bit counter wrap to 1
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(16'(i * 16'h0123), 16'hF0F0, 6'b010_010, 2'b00);
            tick();
        end
        idle();
        repeat (4) tick();
        check("t6_cnt_wrap", cnt, 4'd1);

        for (int i = 0; i < 2000 && !done2; i++) tick();
        check("w16_done", done2, 1);
        check("w16_drained", exp2.size(), 0);
        check("w16_count", pops2 != 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
